// File: rtl/dma_io_peripheral.sv
// rtl/dma_io_peripheral.sv - single-channel DMA request/acknowledge I/O endpoint with FIFO
// Ports: CLK/RESET clock and synchronous active-high reset; ENABLE/DIR arm and direction;
//        DREQ/DACK/IOR_N/IOW_N/EOP_N DMA handshake; DB_IN/DB_OUT/DB_OE data bus;
//        src_* local producer (DIR=0); snk_* local consumer (DIR=1);
//        level FIFO occupancy; done end-of-block pulse; err sticky strobe-on-empty/full.
module dma_io_peripheral #(
   parameter int DATA_WIDTH    = 8,
   parameter int FIFO_DEPTH    = 8,
   parameter int REQ_THRESHOLD = 1
) (
   input  logic                            CLK,
   input  logic                            RESET,
   input  logic                            ENABLE,
   input  logic                            DIR,
   output logic                            DREQ,
   input  logic                            DACK,
   input  logic                            IOR_N,
   input  logic                            IOW_N,
   input  logic                            EOP_N,
   input  logic [DATA_WIDTH-1:0]           DB_IN,
   output logic [DATA_WIDTH-1:0]           DB_OUT,
   output logic                            DB_OE,
   input  logic                            src_valid,
   input  logic [DATA_WIDTH-1:0]           src_data,
   output logic                            src_ready,
   output logic                            snk_valid,
   output logic [DATA_WIDTH-1:0]           snk_data,
   input  logic                            snk_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
   output logic                            done,
   output logic                            err
);
   localparam int LW = $clog2(FIFO_DEPTH+1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] THRESH_L = LW'(REQ_THRESHOLD);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HALT} state_t;
   state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         rd_ptr, wr_ptr;
   logic [LW-1:0]         level_nxt;
   logic [DATA_WIDTH-1:0] wr_q, head, push_data;
   logic                  dir_q, enable_q, strobe_q, eop_pend;
   logic                  dir_eff, strobe_line, strobe_act, complete;
   logic                  fifo_empty, fifo_full, xfer_err;
   logic                  bus_push, bus_pop, loc_push, loc_pop, push, pop;

   function automatic logic req_met(input logic d, input logic [LW-1:0] lvl);
      return d ? ((DEPTH_L - lvl) >= THRESH_L) : (lvl >= THRESH_L);
   endfunction

   // On the cycle ENABLE rises dir_q is not yet updated, so request against the incoming DIR.
   assign dir_eff     = (ENABLE && !enable_q) ? DIR : dir_q;
   assign strobe_line = dir_q ? IOW_N : IOR_N;
   assign strobe_act  = DACK && !strobe_line;
   // Transfer completes on the trailing (rising) edge of the strobe line.
   assign complete    = strobe_q && strobe_line;

   assign fifo_empty  = (level == '0);
   assign fifo_full   = (level == DEPTH_L);
   assign xfer_err    = complete && (dir_q ? fifo_full : fifo_empty);

   assign bus_push    = complete && dir_q && !fifo_full;
   assign bus_pop     = complete && !dir_q && !fifo_empty;
   assign loc_push    = src_valid && src_ready;
   assign loc_pop     = snk_valid && snk_ready;
   assign push        = bus_push || loc_push;
   assign pop         = bus_pop || loc_pop;
   assign push_data   = dir_q ? wr_q : src_data;
   assign level_nxt   = level + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, pop};

   assign head        = fifo_empty ? '0 : mem[rd_ptr];
   assign DB_OUT      = head;
   assign DB_OE       = DACK && !IOR_N && !dir_q;
   assign src_ready   = !dir_q && !fifo_full;
   assign snk_valid   = dir_q && !fifo_empty;
   assign snk_data    = head;
   assign DREQ        = (state == S_REQ);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (ENABLE && req_met(dir_eff, level))
               state_nxt = S_REQ;
         end
         S_REQ: begin
            if (complete) begin
               // An errored transfer leaves the FSM where it was.
               if (!xfer_err)
                  state_nxt = (ENABLE && req_met(dir_q, level_nxt)) ? S_REQ : S_IDLE;
            end else if (!ENABLE && !strobe_act && !strobe_q) begin
               state_nxt = S_IDLE;
            end
         end
         S_HALT: begin
            if (!ENABLE)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (complete && eop_pend)
         state_nxt = S_HALT;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= S_IDLE;
         dir_q    <= 1'b0;
         enable_q <= 1'b0;
         strobe_q <= 1'b0;
         eop_pend <= 1'b0;
         wr_q     <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         enable_q <= ENABLE;
         if (ENABLE && !enable_q)
            dir_q <= DIR;
         strobe_q <= strobe_act;
         if (strobe_act && dir_q)
            wr_q <= DB_IN;
         if (complete)
            eop_pend <= 1'b0;
         else if (strobe_act && !EOP_N)
            eop_pend <= 1'b1;
         done <= complete && eop_pend;
         if (xfer_err)
            err <= 1'b1;
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         level <= level_nxt;
      end
   end

   // Storage is not reset; occupancy gating keeps stale entries invisible.
   always_ff @(posedge CLK) begin
      if (!RESET && push)
         mem[wr_ptr] <= push_data;
   end
endmodule

// File: tb/tb_dma_io_peripheral.sv
// tb/tb_dma_io_peripheral.sv - self-checking bench for dma_io_peripheral
module tb_dma_io_peripheral;
   logic       CLK = 1'b0;
   logic       RESET, ENABLE, DIR, DREQ, DACK, IOR_N, IOW_N, EOP_N;
   logic [7:0] DB_IN, DB_OUT, src_data, snk_data;
   logic       DB_OE, src_valid, src_ready, snk_valid, snk_ready, done, err;
   logic [3:0] level;

   int         n_chk  = 0;
   int         n_fail = 0;
   logic [7:0] sb[$];

   typedef struct {
      logic       en;
      logic       dack;
      logic       ior_n;
      logic       dreq;
      logic       oe;
      logic [3:0] lvl;
   } vec_t;
   vec_t vecs[7];

   dma_io_peripheral #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .REQ_THRESHOLD(1)) dut (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DIR(DIR), .DREQ(DREQ), .DACK(DACK),
      .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N), .DB_IN(DB_IN), .DB_OUT(DB_OUT),
      .DB_OE(DB_OE), .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
      .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready), .level(level),
      .done(done), .err(err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic sb_check(input string name, input logic [7:0] act);
      if (sb.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=<scoreboard empty>", name, act);
      end else begin
         chk(name, act, sb.pop_front());
      end
   endtask

   task automatic push_src(input logic [7:0] b);
      src_valid = 1'b1;
      src_data  = b;
      if (src_ready) sb.push_back(b);
      tick();
      src_valid = 1'b0;
   endtask

   task automatic read_pulse(input logic eop);
      IOR_N = 1'b0;
      EOP_N = !eop;
      #1;
      chk("rd_oe", DB_OE, 1);
      sb_check("rd_data", DB_OUT);
      tick();
      IOR_N = 1'b1;
      EOP_N = 1'b1;
      #1;
      chk("rd_oe_release", DB_OE, 0);
      tick();
   endtask

   task automatic write_pulse(input logic [7:0] d, input logic exp_push);
      DB_IN = d;
      IOW_N = 1'b0;
      if (exp_push) sb.push_back(d);
      tick();
      IOW_N = 1'b1;
      DB_IN = ~d;
      tick();
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
      sb.delete();
   endtask

   initial begin
      RESET = 1'b1; ENABLE = 1'b0; DIR = 1'b0; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1;
      EOP_N = 1'b1; DB_IN = '0; src_valid = 1'b0; src_data = '0; snk_ready = 1'b0;

      //               en    dack  ior_n dreq  oe    lvl
      vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1};
      vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};

      tick();
      tick();
      chk("rst_dreq", DREQ, 0);
      chk("rst_db_oe", DB_OE, 0);
      chk("rst_db_out", DB_OUT, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_level", level, 0);
      chk("rst_src_ready", src_ready, 1);
      chk("rst_snk_valid", snk_valid, 0);
      chk("rst_snk_data", snk_data, 0);
      RESET = 1'b0;

      // DIR=0 block read of two bytes, cycle by cycle
      push_src(8'hA5);
      push_src(8'h3C);
      for (int i = 0; i < 7; i++) begin
         ENABLE = vecs[i].en;
         DACK   = vecs[i].dack;
         IOR_N  = vecs[i].ior_n;
         #1;
         chk($sformatf("t1_dreq[%0d]", i), DREQ, vecs[i].dreq);
         chk($sformatf("t1_oe[%0d]", i), DB_OE, vecs[i].oe);
         chk($sformatf("t1_level[%0d]", i), level, vecs[i].lvl);
         if (vecs[i].oe) sb_check($sformatf("t1_data[%0d]", i), DB_OUT);
         tick();
      end
      chk("t1_db_out_empty", DB_OUT, 0);

      // DIR=1 single write then local pop
      ENABLE = 1'b0;
      tick();
      DIR = 1'b1;
      ENABLE = 1'b1;
      tick();
      chk("t2_dreq", DREQ, 1);
      chk("t2_src_ready", src_ready, 0);
      DACK = 1'b1;
      DB_IN = 8'h5A;
      IOW_N = 1'b0;
      sb.push_back(8'h5A);
      #1;
      chk("t2_oe_on_write", DB_OE, 0);
      tick();
      IOW_N = 1'b1;
      DB_IN = 8'hFF;
      tick();
      chk("t2_level1", level, 1);
      chk("t2_snk_valid", snk_valid, 1);
      chk("t2_dreq_hold", DREQ, 1);
      snk_ready = 1'b1;
      sb_check("t2_snk_data", snk_data);
      tick();
      snk_ready = 1'b0;
      chk("t2_level0", level, 0);
      chk("t2_snk_valid0", snk_valid, 0);

      // DIR=1 fill to full, then a write on full
      for (int i = 0; i < 8; i++) write_pulse(8'($urandom_range(0, 255)), 1'b1);
      chk("t4_level_full", level, 8);
      chk("t4_dreq_full", DREQ, 0);
      chk("t4_err_before", err, 0);
      write_pulse(8'hEE, 1'b0);
      chk("t4_err", err, 1);
      chk("t4_level_kept", level, 8);
      snk_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sb_check($sformatf("t4_drain[%0d]", i), snk_data);
         tick();
      end
      snk_ready = 1'b0;
      chk("t4_level_drained", level, 0);
      chk("t4_err_sticky", err, 1);
      ENABLE = 1'b0;
      DACK = 1'b0;
      tick();

      // DIR=0 EOP during second read of three
      do_reset();
      chk("t3_err_cleared", err, 0);
      DIR = 1'b0;
      push_src(8'h11);
      push_src(8'h22);
      push_src(8'h33);
      ENABLE = 1'b1;
      tick();
      chk("t3_dreq", DREQ, 1);
      DACK = 1'b1;
      read_pulse(1'b0);
      chk("t3_done_none", done, 0);
      read_pulse(1'b1);
      chk("t3_done", done, 1);
      chk("t3_dreq_halt", DREQ, 0);
      chk("t3_level", level, 1);
      tick();
      chk("t3_done_once", done, 0);
      tick();
      tick();
      chk("t3_halt_held", DREQ, 0);
      ENABLE = 1'b0;
      tick();
      ENABLE = 1'b1;
      tick();
      chk("t3_rearm", DREQ, 1);

      // RESET during an active read strobe with four entries
      push_src(8'h44);
      push_src(8'h55);
      push_src(8'h66);
      chk("t5_level4", level, 4);
      IOR_N = 1'b0;
      tick();
      RESET = 1'b1;
      tick();
      chk("t5_dreq", DREQ, 0);
      chk("t5_level", level, 0);
      chk("t5_done", done, 0);
      chk("t5_db_out", DB_OUT, 0);
      chk("t5_src_ready", src_ready, 1);
      chk("t5_snk_valid", snk_valid, 0);
      IOR_N = 1'b1;
      RESET = 1'b0;
      ENABLE = 1'b0;
      sb.delete();
      tick();
      chk("t5_level_after", level, 0);
      chk("t5_done_after", done, 0);
      chk("t5_err_after", err, 0);

      // Strobes without DACK, then concurrent local push and bus pop
      DACK = 1'b0;
      push_src(8'hAA);
      push_src(8'h55);
      ENABLE = 1'b1;
      tick();
      IOR_N = 1'b0;
      #1;
      chk("t6_oe_nodack", DB_OE, 0);
      tick();
      IOR_N = 1'b1;
      tick();
      chk("t6_level_nodack", level, 2);
      chk("t6_done_nodack", done, 0);
      DACK = 1'b1;
      IOR_N = 1'b0;
      #1;
      sb_check("t6_rd_data", DB_OUT);
      tick();
      IOR_N = 1'b1;
      src_valid = 1'b1;
      src_data = 8'h77;
      if (src_ready) sb.push_back(8'h77);
      tick();
      src_valid = 1'b0;
      chk("t6_level_same", level, 2);
      read_pulse(1'b0);
      read_pulse(1'b0);
      chk("t6_level_end", level, 0);
      chk("t6_err_end", err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dma_io_peripheral.md
# dma_io_peripheral

Single-channel I/O endpoint on the device side of the DMA request/acknowledge interface. It buffers bytes in an internal FIFO, raises DREQ toward the DMA controller, and completes I/O read (device-to-memory) or I/O write (memory-to-device) strobes issued while DACK is active. It halts on EOP_N and presents a valid/ready stream to local device logic. It serves as both the peripheral model in DMA controller benches and the reusable endpoint in the system.

## Interface
- DATA_WIDTH, 8, bus and FIFO data width
- FIFO_DEPTH, 8, FIFO entries (power of two, ≥2)
- REQ_THRESHOLD, 1, minimum FIFO entries (DIR=0) or free slots (DIR=1) needed to request

- CLK  in  1  clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- ENABLE  in  1  arm channel; DIR is latched on the ENABLE rising edge
- DIR  in  1  0 = device-to-memory (IOR_N), 1 = memory-to-device (IOW_N)
- DREQ  out  1  DMA request, active-high, registered
- DACK  in  1  DMA acknowledge, active-high
- IOR_N  in  1  I/O read strobe, active-low
- IOW_N  in  1  I/O write strobe, active-low
- EOP_N  in  1  terminal count / end of process, active-low
- DB_IN  in  DATA_WIDTH  data bus from controller/memory
- DB_OUT  out  DATA_WIDTH  data bus to controller
- DB_OE  out  1  DB_OUT drive enable
- src_valid / src_data / src_ready  in / in DATA_WIDTH / out  local producer into FIFO (DIR=0)
- snk_valid / snk_data / snk_ready  out / out DATA_WIDTH / in  local consumer from FIFO (DIR=1)
- level  out  clog2(FIFO_DEPTH+1)  FIFO occupancy
- done  out  1  one-cycle pulse when EOP terminates the block
- err  out  1  sticky strobe-on-empty/full flag; cleared by RESET only

## Operation
- dir_q is latched from DIR when ENABLE rises. DIR changes while enabled are ignored.
- Local side:
  - src_ready = !dir_q && level<FIFO_DEPTH
  - snk_valid = dir_q && level>0; snk_data = FIFO head
- Request condition:
  - armed = ENABLE && state≠HALT
  - DIR=0: level ≥ REQ_THRESHOLD
  - DIR=1: FIFO_DEPTH−level ≥ REQ_THRESHOLD
- FSM:
  - IDLE (DREQ=0) → REQ when armed and request condition met.
  - REQ (DREQ=1). On strobe completion:
    - EOP latched → HALT.
    - Request condition still met → stay REQ.
    - Otherwise → IDLE.
  - REQ with ENABLE low and no strobe active → IDLE.
  - HALT (DREQ=0) → IDLE when ENABLE is sampled low.
- Strobe: active strobe = DACK && !IOR_N (dir_q=0) or DACK && !IOW_N (dir_q=1). Completion is the first clock where the strobe line is sampled high after a cycle in which the strobe was active.
- DIR=0 read:
  - DB_OE = DACK && !IOR_N && !dir_q (combinational).
  - DB_OUT = FIFO head, or 0 if empty.
  - Pop on completion.
- DIR=1 write: DB_IN is registered every active-strobe cycle; the last registered value is pushed on completion.
- EOP_N sampled low during any active-strobe cycle sets eop_pend. On completion:
  - done pulses.
  - FSM enters HALT.
  - eop_pend clears.
- Completion with the FIFO empty (read) or full (write): no pop/push, err set, FSM otherwise unchanged.
- Strobes without DACK are ignored entirely.
- Simultaneous local push and bus pop (or bus push and local pop) in one cycle: both take effect; level unchanged.

## Timing
- Reset values:
  - DREQ=0, DB_OE=0, DB_OUT=0, done=0, err=0, level=0
  - src_ready=1, snk_valid=0, snk_data=0
  - state=IDLE, dir_q=0, eop_pend=0
- DREQ asserts 1 cycle after the request condition becomes true in IDLE.
- DREQ deasserts in the cycle after the completing strobe, if the condition fails or EOP occurs.
- FIFO update and level change are visible 1 cycle after completion. DB_OUT follows the new head the same cycle.
- RESET mid-strobe: FIFO flushed, no push/pop, no done; the strobe's trailing edge is ignored.
- FIFO pointers wrap modulo FIFO_DEPTH; level saturates logically at 0..FIFO_DEPTH.

## Test plan
- DIR=0, REQ_THRESHOLD=1, push 0xA5,0x3C; ENABLE → DREQ=1 next cycle; DACK with two IOR_N pulses → DB_OUT 0xA5 then 0x3C, DB_OE only while strobe is low, level 2→1→0, DREQ=0 after the second pulse.
- DIR=1, DEPTH=8, ENABLE → DREQ=1; IOW_N pulse with DB_IN=0x5A → level=1, snk_data=0x5A; snk_ready pops → level=0.
- DIR=0 with three entries; EOP_N low during the second IOR_N → done pulses once, DREQ=0, level=1, HALT held until ENABLE low, then IDLE.
- DIR=1 with FIFO full (8 entries); forced IOW_N with DACK → err=1, level stays 8, no data corruption.
- RESET asserted mid IOR_N strobe with level=4 → all outputs at reset values next cycle, level=0, no pop or done on the strobe release.
- IOR_N pulses with DACK=0 → no pop, DB_OE=0; simultaneous src push and bus pop → level unchanged.
